uart_rx_framer: RTL and testbench

UART_RX_FRAMER -- requirements
Module: uart_rx_framer

---
 rtl/uart_rx_framer.sv | 119 +++++++++++
 tb/tb_uart_rx_framer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_framer.sv
// uart_rx_framer: turns a UART byte stream into checksummed frames and queues payload bytes
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   s_tick            baud sample tick, drives the inter-byte timeout
//   rx_done_tick      one-cycle strobe qualifying rx_data
//   rx_data           received byte
//   m_data, m_last    FIFO head byte and its end-of-frame marker
//   m_valid, m_ready  FIFO handshake, pop on m_valid & m_ready
//   frame_ok          one-cycle pulse, checksum good and nothing dropped
//   frame_err         one-cycle pulse, frame aborted, LEN=0 or bad checksum
//   busy              framer is inside a frame
module uart_rx_framer #(
  parameter int DBIT_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT_TICKS = 640,
  parameter logic [7:0] SOF_BYTE = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_tick,
  input  logic                  rx_done_tick,
  input  logic [DBIT_WIDTH-1:0] rx_data,
  output logic [DBIT_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  frame_ok,
  output logic                  frame_err,
  output logic                  busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_TICKS);
  typedef enum logic [1:0] {HUNT, LEN, PAYLOAD, CHK} state_t;
  state_t r_state, w_next;
  logic [DBIT_WIDTH-1:0] r_sum, r_rem;
  logic r_ovf, r_ok, r_err;
  logic [TW-1:0] r_tcnt;
  logic [DBIT_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_lastv;
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_count;
  logic w_ok, w_err, w_to, w_pop, w_push_req, w_push, w_full;
  assign m_valid = r_count != '0;
  assign w_full = r_count == CW'(FIFO_DEPTH);
  assign w_pop = m_valid & m_ready;
  assign w_push_req = rx_done_tick && r_state == PAYLOAD;
  // a full FIFO can still take a byte when the head leaves in the same cycle
  assign w_push = w_push_req && (!w_full || w_pop);
  assign w_to = r_state != HUNT && r_tcnt >= TMAX;
  assign m_data = m_valid ? r_mem[r_rd] : '0;
  assign m_last = m_valid & r_lastv[r_rd];
  assign frame_ok = r_ok;
  assign frame_err = r_err;
  assign busy = r_state != HUNT;
  always_comb begin
    w_next = r_state;
    w_ok = 1'b0;
    w_err = 1'b0;
    // a byte arriving in the same cycle as the timeout wins
    if (rx_done_tick) begin
      unique case (r_state)
        HUNT: w_next = rx_data == SOF_BYTE ? LEN : HUNT;
        LEN: begin
          w_err = rx_data == '0;
          w_next = w_err ? HUNT : PAYLOAD;
        end
        PAYLOAD: w_next = r_rem == DBIT_WIDTH'(1) ? CHK : PAYLOAD;
        CHK: begin
          w_ok = DBIT_WIDTH'(r_sum + rx_data) == '0 && !r_ovf;
          w_err = !w_ok;
          w_next = HUNT;
        end
      endcase
    end else if (w_to) begin
      w_err = 1'b1;
      w_next = HUNT;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= HUNT;
      r_sum <= '0;
      r_rem <= '0;
      r_ovf <= 1'b0;
      r_ok <= 1'b0;
      r_err <= 1'b0;
      r_tcnt <= '0;
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      r_ok <= w_ok;
      r_err <= w_err;
      if (rx_done_tick && r_state == HUNT && rx_data == SOF_BYTE) r_ovf <= 1'b0;
      else if (w_push_req && !w_push) r_ovf <= 1'b1;
      if (rx_done_tick && r_state == LEN) begin
        r_sum <= rx_data;
        r_rem <= rx_data;
      end else if (w_push_req) begin
        r_sum <= r_sum + rx_data;
        r_rem <= r_rem - 1'b1;
      end
      r_tcnt <= (rx_done_tick || w_next == HUNT) ? '0 : (s_tick && r_tcnt != TMAX) ? r_tcnt + 1'b1 : r_tcnt;
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
  // storage needs no reset: m_valid gates what leaves
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr] <= rx_data;
      r_lastv[r_wr] <= r_rem == DBIT_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_uart_rx_framer.sv
// tb_uart_rx_framer: directed and random frames checked against a frame-level model
module tb_uart_rx_framer;
  localparam int TO = 16;
  localparam int DEPTH = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s_tick = 1'b0;
  logic rx_done_tick = 1'b0;
  logic [7:0] rx_data = '0;
  logic m_ready = 1'b1;
  logic [7:0] m_data;
  logic m_last, m_valid, frame_ok, frame_err, busy;
  int errors = 0;
  int checks = 0;
  int n_ok = 0;
  int n_err = 0;
  int n_both = 0;
  int exp_ok = 0;
  int exp_err = 0;
  logic [8:0] got [$];
  logic [8:0] expq [$];
  logic [7:0] pl [256];
  always #5 clk = ~clk;
  uart_rx_framer #(.TIMEOUT_TICKS(TO), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .s_tick(s_tick), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
    .m_data(m_data), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
    .frame_ok(frame_ok), .frame_err(frame_err), .busy(busy)
  );
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_ok) n_ok++;
      if (frame_err) n_err++;
      if (frame_ok && frame_err) n_both++;
      if (m_valid && m_ready) got.push_back({m_last, m_data});
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done_tick = 1'b1;
    tick();
    rx_done_tick = 1'b0;
  endtask
  task automatic gap(input int maxgap);
    repeat ($urandom_range(0, maxgap)) tick();
  endtask
  // model: frame is good when LEN + payload + CHK wraps to zero and no byte was dropped;
  // only the first cap payload bytes fit in the FIFO
  task automatic send_frame(input int len, input logic [7:0] c, input int cap, input int maxgap);
    int s;
    bit ok;
    s = len + int'(c);
    send_byte(8'hA5);
    gap(maxgap);
    send_byte(8'(len));
    for (int i = 0; i < len; i++) begin
      gap(maxgap);
      send_byte(pl[i]);
      s += int'(pl[i]);
      if (i < cap) expq.push_back({i == len - 1, pl[i]});
    end
    gap(maxgap);
    send_byte(c);
    ok = (s % 256 == 0) && len <= cap;
    if (ok) exp_ok++;
    else exp_err++;
    chk("frame_ok_pulse", {31'b0, frame_ok}, {31'b0, ok});
    chk("frame_err_pulse", {31'b0, frame_err}, {31'b0, !ok});
  endtask
  task automatic drain_compare();
    for (int i = 0; i < 64 && m_valid; i++) tick();
    tick();
    chk("drain_empty", {31'b0, m_valid}, 32'd0);
    chk("out_count", got.size(), expq.size());
    for (int i = 0; i < expq.size(); i++)
      chk("out_byte", i < got.size() ? {23'b0, got[i]} : 32'hFFFF_FFFF, {23'b0, expq[i]});
    chk("ok_count", n_ok, exp_ok);
    chk("err_count", n_err, exp_err);
    chk("both_pulses", n_both, 0);
    got.delete();
    expq.delete();
  endtask
  function automatic logic [7:0] good_chk(input int len);
    int s;
    s = len;
    for (int i = 0; i < len; i++) s += int'(pl[i]);
    return 8'(256 - s % 256);
  endfunction
  initial begin
    #1;
    chk("rst_m_valid", {31'b0, m_valid}, 32'd0);
    chk("rst_m_last", {31'b0, m_last}, 32'd0);
    chk("rst_m_data", {24'b0, m_data}, 32'd0);
    chk("rst_frame_ok", {31'b0, frame_ok}, 32'd0);
    chk("rst_frame_err", {31'b0, frame_err}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    send_frame(3, 8'h97, 999, 0);
    drain_compare();
    pl[0] = 8'h10; pl[1] = 8'h20;
    send_frame(2, 8'h00, 999, 1);
    drain_compare();
    send_byte(8'h00);
    chk("noise00_busy", {31'b0, busy}, 32'd0);
    send_byte(8'hFF);
    chk("noiseFF_busy", {31'b0, busy}, 32'd0);
    send_byte(8'hA5);
    chk("sof_busy", {31'b0, busy}, 32'd1);
    send_byte(8'h00);
    exp_err++;
    chk("len0_err", {31'b0, frame_err}, 32'd1);
    chk("len0_busy", {31'b0, busy}, 32'd0);
    drain_compare();
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) pl[i] = 8'(8'h40 + i);
    send_frame(10, good_chk(10), DEPTH, 0);
    chk("ovf_valid_held", {31'b0, m_valid}, 32'd1);
    m_ready = 1'b1;
    drain_compare();
    send_byte(8'hA5);
    send_byte(8'h04);
    send_byte(8'h01);
    expq.push_back({1'b0, 8'h01});
    for (int i = 0; i < TO; i++) begin
      if (i == TO - 1) chk("pre_timeout_busy", {31'b0, busy}, 32'd1);
      s_tick = 1'b1;
      tick();
      s_tick = 1'b0;
    end
    chk("pre_timeout_err", {31'b0, frame_err}, 32'd0);
    tick();
    exp_err++;
    chk("timeout_err", {31'b0, frame_err}, 32'd1);
    chk("timeout_busy", {31'b0, busy}, 32'd0);
    send_byte(8'h05);
    chk("post_timeout_busy", {31'b0, busy}, 32'd0);
    drain_compare();
    m_ready = 1'b0;
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h11);
    chk("midrst_busy_before", {31'b0, busy}, 32'd1);
    chk("midrst_valid_before", {31'b0, m_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_valid", {31'b0, m_valid}, 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    m_ready = 1'b1;
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    send_frame(3, good_chk(3), 999, 0);
    drain_compare();
    for (int f = 0; f < 12; f++) begin
      int len;
      logic [7:0] c;
      repeat ($urandom_range(0, 2)) begin
        logic [7:0] nb;
        nb = 8'($urandom_range(0, 255));
        if (nb == 8'hA5) nb = 8'h5A;
        send_byte(nb);
        chk("rand_noise_busy", {31'b0, busy}, 32'd0);
      end
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) pl[i] = 8'($urandom_range(0, 255));
      c = good_chk(len);
      if ($urandom_range(0, 9) < 3) c = c + 8'($urandom_range(1, 255));
      send_frame(len, c, 999, 2);
    end
    drain_compare();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
